avalon_mem_port: RTL
====================

Name: avalon_mem_port

Overview:
Parametrised Avalon-MM master front end between the CPU datapath and the memory bus. It replaces the fixed-width, zero-wait memory mux with a registered request/response engine.
- Holds a transaction through any number of waitrequest cycles.
- Generates byte lanes for byte, half and word accesses, and sign/zero-extends load data.
- Reports misaligned accesses without touching the bus.

Parameters:
DATA_WIDTH, 32, Avalon data width; legal values 32 or 64.
ADDR_WIDTH, 32, byte-address width on both sides.
TIMEOUT_CYCLES, 1024, waitrequest cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request strobe
req_ready  out  1  high only in IDLE; request accepted on edge where req_valid&&req_ready
req_write  in  1  1=store, 0=load
req_size  in  2  mem_size_t: byte/half/word
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_error  out  1  valid with resp_valid; misaligned or timeout
address  out  ADDR_WIDTH  Avalon byte address, low log2(DATA_WIDTH/8) bits zero
write  out  1  Avalon write
read  out  1  Avalon read
waitrequest  in  1  Avalon stall
writedata  out  DATA_WIDTH  lane-steered store data
byteenable  out  DATA_WIDTH/8  active lanes
readdata  in  DATA_WIDTH  Avalon read data

Behaviour:
- Reset (sync, edge with reset=1): state=IDLE; read, write, resp_valid, resp_error = 0; address, writedata, byteenable, resp_rdata = 0; req_ready=1 from first cycle after reset. A reset mid-transaction aborts it: read/write low after that edge, no resp_valid.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, ERR.
- IDLE:
  - On accept, misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> ERR.
  - Else load -> RD_REQ, store -> WR_REQ.
  - address, byteenable, writedata, and captured size/signed/offset are registered at the accept edge.
- RD_REQ: read=1. Held, with all bus outputs stable, while waitrequest=1. On the edge with waitrequest=0 -> RD_DATA, read=0.
- RD_DATA: readdata valid this cycle, captured at the edge. resp_valid=1 the following cycle -> IDLE.
- WR_REQ: write=1. Held while waitrequest=1. On the edge with waitrequest=0 -> IDLE with resp_valid=1, resp_rdata=0.
- ERR: one cycle, then resp_valid=1, resp_error=1 -> IDLE. read and write are never asserted.
- Zero-wait latency: load accept edge T0 -> resp_valid in cycle T0+3; store -> T0+2; misaligned -> T0+2.
- Lane mapping:
  - Little-endian: lane n = byte offset n within the bus word.
  - Byte: byteenable one-hot at offset, data replicated to every lane.
  - Half: 2'b11 shifted by offset.
  - Word: 4'hF shifted by offset (offset 0 or 4 at 64-bit).
- Load result: readdata >> 8*offset, truncated to size, then sign-extended if req_signed else zero-extended. Word loads ignore req_signed.
- req_valid while not in IDLE is ignored (req_ready=0). resp_valid has no backpressure. A new request may be accepted in the cycle resp_valid is high (state already IDLE).
- read and write are never both high.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter increments each cycle waitrequest=1 in RD_REQ/WR_REQ. On reaching TIMEOUT_CYCLES, read/write drop, the block goes to ERR and returns resp_error=1 with resp_rdata=0.
- Undefined: no counter; waits indefinitely; resp_error only for misalignment; TIMEOUT_CYCLES unused.

Decomposition:
- Package mem_port_pkg:
  - mem_size_t enum: SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2.
  - mem_state_t enum for the states.
  - Function computing lane-offset width from DATA_WIDTH.
- One combinational sub-module, mem_lane_align: byteenable/writedata generation and readdata shift/extension. The FSM, registers and timeout counter stay in the top.

Test Plan:
- Word load, zero wait, addr 0x1000, readdata 0xDEADBEEF -> read high exactly 1 cycle, address 0x1000, byteenable 4'hF, resp_rdata 0xDEADBEEF at accept+3.
- Signed byte load addr 0x1003, readdata 0x80FFFFFF, 3 waitrequest cycles -> read held 4 cycles, address 0x1000, resp_rdata 0xFFFFFF80. Same with req_signed=0 -> 0x00000080.
- Half store addr 0x2002, wdata 0x0000ABCD -> write 1 cycle, byteenable 4'b1100, writedata[31:16]=0xABCD, resp_valid at accept+2, resp_error=0.
- Word load at 0x2001 -> no read/write ever, resp_valid+resp_error at accept+2, resp_rdata=0. Back-to-back request accepted that same cycle.
- Reset asserted during RD_REQ with waitrequest=1 -> read=0 next cycle, no resp_valid, req_ready=1.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> read drops after 8 cycles, resp_error=1. Without macro, read stays high for 100 cycles.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the Avalon-MM memory port: access sizes,
// engine states, lane-offset width and misalignment rule.
package mem_port_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_ERR
  } mem_state_t;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int unsigned lane_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byteenable/writedata for stores and
// shift plus sign/zero extension of read data for loads.
module mem_lane_align
  import mem_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned OFF_W = lane_off_width(DATA_WIDTH),
  localparam int unsigned BE_W = DATA_WIDTH / 8
) (
  input  mem_size_t              req_size,
  input  logic [OFF_W-1:0]       req_off,
  input  logic [31:0]            req_wdata,
  output logic [BE_W-1:0]        byteenable_c,
  output logic [DATA_WIDTH-1:0]  writedata_c,
  input  mem_size_t              rd_size,
  input  logic [OFF_W-1:0]       rd_off,
  input  logic                   rd_signed,
  input  logic [DATA_WIDTH-1:0]  readdata,
  output logic [31:0]            rdata_c
);

  logic [31:0] rd_word_c;

  // Store data is replicated across the bus so every legal offset sees it.
  always_comb begin
    byteenable_c = '0;
    writedata_c  = '0;
    case (req_size)
      SIZE_BYTE: begin
        byteenable_c = BE_W'(1) << req_off;
        writedata_c  = {BE_W{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        byteenable_c = BE_W'(3) << req_off;
        writedata_c  = {(BE_W / 2){req_wdata[15:0]}};
      end
      default: begin
        byteenable_c = BE_W'(15) << req_off;
        writedata_c  = {(BE_W / 4){req_wdata}};
      end
    endcase
  end

  assign rd_word_c = 32'(readdata >> {rd_off, 3'b000});

  always_comb begin
    rdata_c = rd_word_c;
    case (rd_size)
      SIZE_BYTE: rdata_c = {{24{rd_signed & rd_word_c[7]}}, rd_word_c[7:0]};
      SIZE_HALF: rdata_c = {{16{rd_signed & rd_word_c[15]}}, rd_word_c[15:0]};
      default:   ;
    endcase
  end

endmodule

// File: rtl/avalon_mem_port.sv
// Avalon-MM master front end: registered request/response engine with
// waitrequest hold, lane steering and misalignment errors.
// Optional MEM_TIMEOUT_EN aborts a bus access after TIMEOUT_CYCLES stalls.
module avalon_mem_port
  import mem_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  mem_size_t                req_size,
  input  logic                     req_signed,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic [ADDR_WIDTH-1:0]    address,
  output logic                     write,
  output logic                     read,
  input  logic                     waitrequest,
  output logic [DATA_WIDTH-1:0]    writedata,
  output logic [DATA_WIDTH/8-1:0]  byteenable,
  input  logic [DATA_WIDTH-1:0]    readdata
);

  localparam int unsigned OFF_W = lane_off_width(DATA_WIDTH);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("avalon_mem_port: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("avalon_mem_port: TIMEOUT_CYCLES must be non-zero");
  end

  mem_state_t             state_q, state_d;
  logic                   accept_c, misaligned_c, timeout_c;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [BE_W-1:0]        byteenable_q, byteenable_d, lane_be_c;
  logic [DATA_WIDTH-1:0]  writedata_q, writedata_d, lane_wdata_c;
  logic                   read_q, read_d, write_q, write_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_error_q, resp_error_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d, lane_rdata_c;
  mem_size_t              size_q, size_d;
  logic                   signed_q, signed_d;
  logic [OFF_W-1:0]       off_q, off_d;

  assign req_ready    = (state_q == ST_IDLE);
  assign accept_c     = req_valid && req_ready;
  assign misaligned_c = is_misaligned(req_size, req_addr[1:0]);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_wait_c;

  // Counts consecutive stalled cycles of the current bus access.
  assign bus_wait_c = ((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ)) && waitrequest;
  assign timeout_c  = bus_wait_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (bus_wait_c) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .req_size     (req_size),
    .req_off      (req_addr[OFF_W-1:0]),
    .req_wdata    (req_wdata),
    .byteenable_c (lane_be_c),
    .writedata_c  (lane_wdata_c),
    .rd_size      (size_q),
    .rd_off       (off_q),
    .rd_signed    (signed_q),
    .readdata     (readdata),
    .rdata_c      (lane_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (misaligned_c)   state_d = ST_ERR;
          else if (req_write) state_d = ST_WR_REQ;
          else                state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!waitrequest)   state_d = ST_RD_DATA;
        else if (timeout_c) state_d = ST_ERR;
      end
      ST_RD_DATA: state_d = ST_IDLE;
      ST_WR_REQ: begin
        if (!waitrequest)   state_d = ST_IDLE;
        else if (timeout_c) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes follow the next state so they are flop outputs aligned to it.
  always_comb begin
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    read_d       = (state_d == ST_RD_REQ);
    write_d      = (state_d == ST_WR_REQ);
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    if (accept_c) begin
      address_d    = {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      byteenable_d = lane_be_c;
      writedata_d  = lane_wdata_c;
      size_d       = req_size;
      signed_d     = req_signed;
      off_d        = req_addr[OFF_W-1:0];
    end
    case (state_q)
      ST_RD_DATA: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = lane_rdata_c;
      end
      ST_WR_REQ: begin
        if (!waitrequest) resp_valid_d = 1'b1;
      end
      ST_ERR: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      off_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      read_q       <= read_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign read       = read_q;
  assign write      = write_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

endmodule
